// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational ALU between two requesters:
//   req0 - core execute path
//   req1 - auxiliary unit (address / compare engine)
//
// One operation is in flight at a time. The accepted operands are registered
// onto the ALU inputs. The ALU settles for one cycle. Its result and zero
// flags are then registered and returned to the requester that won.
//
//   IDLE --handshake--> EXEC --capture--> RESP --rsp_ready--> IDLE
//
// With rsp_ready tied high, rsp_valid is first seen two cycles after the
// handshake cycle. A new operation can be issued every three cycles.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   - round-robin. When both requesters are valid, the pointer
//               chooses the winner. After every grant the pointer moves to
//               the other requester.
//   undefined - fixed priority. When both are valid, req0 always wins and
//               there is no pointer register. req1 can starve; this is
//               intended.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   reqN_valid / reqN_ready   N=0,1 request handshake (ready is combinational)
//   reqN_a / reqN_b / reqN_mode  operands and ALU mode, sampled only at handshake
//   rsp_valid / rsp_ready     response handshake; rsp_* held until consumed
//   rsp_id                    owner of the response (0 = req0, 1 = req1)
//   rsp_result / rsp_zero     registered ALU result / zero flags
//   alu_a / alu_b / alu_mode  registered drive of the shared ALU inputs
//   alu_result / alu_zero     ALU outputs
//
// ALU encodings follow param.v:
//   modes      ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7
//              BINARY_signed=8 BINARY_unsigned=9
//   zero flags EQUAL=00 GREATER=01 LESS=10 OTHER=11
// This block does not decode or check mode codes. Every code passes straight
// through to the ALU.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int MODE_W = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [MODE_W-1:0] req0_mode,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [MODE_W-1:0] req1_mode,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [1:0]        rsp_zero,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [MODE_W-1:0] alu_mode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [1:0]        alu_zero
);

  localparam logic [MODE_W-1:0] MODE_ADD   = '0;
  localparam logic [1:0]        ZERO_EQUAL = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;

  logic              grant_valid;  // a handshake happens this cycle
  logic              grant_id;     // which requester wins (valid only with grant_valid)
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [MODE_W-1:0] sel_mode;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
  logic rr_ptr;  // requester that wins the next tie

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = rr_ptr;
    end else begin
      grant_id = req1_valid;
    end
  end
`else
  always_comb begin
    grant_id = 1'b0;
    if (req1_valid && !req0_valid) begin
      grant_id = 1'b1;
    end
  end
`endif

  // Ready is combinational, and only one ready can be high at a time. It is
  // also forced low while rst is held. Otherwise the IDLE reset state would
  // show ready to a valid requester while the block is still in reset.
  assign grant_valid = (state == S_IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready  = grant_valid && !grant_id;
  assign req1_ready  = grant_valid &&  grant_id;

  // Operand select for the winning requester.
  always_comb begin
    sel_a    = req0_a;
    sel_b    = req0_b;
    sel_mode = req0_mode;
    if (grant_id) begin
      sel_a    = req1_a;
      sel_b    = req1_b;
      sel_mode = req1_mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM, ALU input registers and response registers
  // ---------------------------------------------------------------------------
  // NOTE: all state is assigned with non-blocking (<=). Every register then
  // updates from values sampled at the same clock edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= ZERO_EQUAL;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_mode   <= MODE_ADD;
    end else begin
      case (state)
        S_IDLE: begin
          // When there is no handshake the ALU registers keep their values,
          // so the ALU inputs stay quiet.
          if (grant_valid) begin
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_mode <= sel_mode;
            rsp_id   <= grant_id;
            state    <= S_EXEC;
          end
        end

        S_EXEC: begin
          // The ALU has had a full cycle to settle on the registered operands.
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_RR_EN
  // After every grant, the other requester wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (grant_valid) begin
      rr_ptr <= ~grant_id;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter. The bench models the shared ALU
// behaviourally and drives alu_result / alu_zero from the DUT's alu_* outputs.
// Directed scenarios check reset, single operations, compares, shifts,
// back-pressure, contention and reset during a response. A randomized phase
// is then checked against a transaction-level model of the arbiter. That
// model tracks the outstanding operation, its age and the tie-break
// preference.
// Build with +define+ALU_ARB_RR_EN to check the round-robin configuration.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int DATA_W = 32;
  localparam int MODE_W = 4;

  localparam logic [3:0] M_ADD = 4'd0;
  localparam logic [3:0] M_SUB = 4'd1;
  localparam logic [3:0] M_AND = 4'd2;
  localparam logic [3:0] M_OR  = 4'd3;
  localparam logic [3:0] M_XOR = 4'd4;
  localparam logic [3:0] M_SLL = 4'd5;
  localparam logic [3:0] M_SRL = 4'd6;
  localparam logic [3:0] M_SRA = 4'd7;
  localparam logic [3:0] M_BS  = 4'd8;
  localparam logic [3:0] M_BU  = 4'd9;

  localparam logic [1:0] Z_EQUAL   = 2'b00;
  localparam logic [1:0] Z_GREATER = 2'b01;
  localparam logic [1:0] Z_LESS    = 2'b10;

  logic              clk;
  logic              rst;
  logic              req0_valid, req0_ready;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic [MODE_W-1:0] req0_mode;
  logic              req1_valid, req1_ready;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [MODE_W-1:0] req1_mode;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic [1:0]        rsp_zero;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [MODE_W-1:0] alu_mode;
  logic [1:0]        alu_zero;

  int checks   = 0;
  int failures = 0;

  alu_share_arbiter #(.DATA_W(DATA_W), .MODE_W(MODE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_mode  (req1_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {zero, result}. The zero flags are the signed
  // comparison of the result against 0. Codes outside the list give an
  // arbitrary mix of the inputs, so any pass-through error shows up.
  function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] m);
    logic [31:0] r;
    logic [1:0]  z;
    case (m)
      M_ADD:   r = a + b;
      M_SUB:   r = a - b;
      M_AND:   r = a & b;
      M_OR:    r = a | b;
      M_XOR:   r = a ^ b;
      M_SLL:   r = a << b[4:0];
      M_SRL:   r = a >> b[4:0];
      M_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
      M_BS:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      M_BU:    r = (a < b) ? 32'd1 : 32'd0;
      default: r = a ^ {b[15:0], b[31:16]} ^ {28'h0, m};
    endcase
    if (r == 32'd0)  z = Z_EQUAL;
    else if (r[31])  z = Z_LESS;
    else             z = Z_GREATER;
    return {z, r};
  endfunction

  always_comb {alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_mode);

  // Watchdog: the bench must always end on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Helpers (stimulus only). All tasks start and end 1 time unit after a
  // rising edge. DUT outputs are sampled on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issues one operation from requester 'id' and waits for the first response
  // cycle. lat counts cycles from the handshake cycle to the first cycle with
  // rsp_valid high. Returns 1 time unit after the edge that ends that cycle.
  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] m, output bit hs_ok, output bit rsp_ok,
                        output int lat, output bit got_id, output logic [31:0] res,
                        output logic [1:0] z);
    hs_ok  = 1'b0;
    rsp_ok = 1'b0;
    lat    = 0;
    got_id = 1'b0;
    res    = '0;
    z      = '0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_mode = m;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_mode = m;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        hs_ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
    if (hs_ok) begin
      lat = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rsp_valid) begin
          rsp_ok = 1'b1;
          got_id = rsp_id;
          res    = rsp_result;
          z      = rsp_zero;
          break;
        end
        lat++;
        @(posedge clk);
        #1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Checks one directed operation against constant expectations.
  task automatic do_directed(input string name, input bit id, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] m,
                             input logic [31:0] exp_res, input logic [1:0] exp_z);
    bit hs_ok, rsp_ok, got_id;
    int lat;
    logic [31:0] res;
    logic [1:0]  z;
    run_op(id, a, b, m, hs_ok, rsp_ok, lat, got_id, res, z);
    checks++;
    if (!(hs_ok && rsp_ok)) begin
      failures++;
      $display("FAIL %s handshake/response: hs_ok=%0d rsp_ok=%0d required 1/1", name, hs_ok, rsp_ok);
    end
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles required 2", name, lat);
    end
    checks++;
    if (got_id !== id) begin
      failures++;
      $display("FAIL %s rsp_id: got %0d required %0d", name, got_id, id);
    end
    checks++;
    if (res !== exp_res) begin
      failures++;
      $display("FAIL %s rsp_result: got %h required %h", name, res, exp_res);
    end
    checks++;
    if (z !== exp_z) begin
      failures++;
      $display("FAIL %s rsp_zero: got %b required %b", name, z, exp_z);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst        = 1'b1;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h1111_2222; req0_b = 32'h3; req0_mode = M_SUB;
    req1_valid = 1'b1; req1_a = 32'h4444_5555; req1_b = 32'h6; req1_mode = M_XOR;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset ready/valid: got r0=%b r1=%b v=%b required 0/0/0",
               req0_ready, req1_ready, rsp_valid);
    end
    checks++;
    if ({rsp_id, rsp_zero, alu_mode} !== {1'b0, Z_EQUAL, M_ADD}) begin
      failures++;
      $display("FAIL reset id/zero/mode: got %b/%b/%h required 0/%b/%h",
               rsp_id, rsp_zero, alu_mode, Z_EQUAL, M_ADD);
    end
    checks++;
    if ({rsp_result, alu_a, alu_b} !== 96'd0) begin
      failures++;
      $display("FAIL reset data: got result=%h alu_a=%h alu_b=%h required 0",
               rsp_result, alu_a, alu_b);
    end
    apply_reset();
  endtask

  task automatic test_single_op();
    do_directed("add_5_7", 1'b0, 32'd5, 32'd7, M_ADD, 32'd12, Z_GREATER);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_5_7 rsp_valid after consume: got %b required 0", rsp_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_compare();
    do_directed("bin_signed", 1'b1, 32'hFFFF_FFFF, 32'd1, M_BS, 32'd1, Z_GREATER);
    do_directed("bin_unsigned", 1'b1, 32'hFFFF_FFFF, 32'd1, M_BU, 32'd0, Z_EQUAL);
  endtask

  task automatic test_sub_shift();
    do_directed("sub_3_5", 1'b0, 32'd3, 32'd5, M_SUB, 32'hFFFF_FFFE, Z_LESS);
    do_directed("sll_1_31", 1'b0, 32'd1, 32'd31, M_SLL, 32'h8000_0000, Z_LESS);
  endtask

  task automatic test_back_pressure();
    bit hs_ok, rsp_ok, got_id;
    int lat;
    logic [31:0] res;
    logic [1:0]  z;
    apply_reset();
    rsp_ready = 1'b0;
    run_op(1'b0, 32'h0000_1234, 32'h0000_1111, M_ADD, hs_ok, rsp_ok, lat, got_id, res, z);
    checks++;
    if (!(hs_ok && rsp_ok) || res !== 32'h0000_2345) begin
      failures++;
      $display("FAIL backpressure first rsp: ok=%0d/%0d result=%h required 1/1/00002345",
               hs_ok, rsp_ok, res);
    end
    // Both requesters push while the response is stalled.
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_mode = M_ADD;
    req1_valid = 1'b1; req1_a = 32'd200; req1_b = 32'd2; req1_mode = M_ADD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero, req0_ready, req1_ready} !==
          {1'b1, 1'b0, 32'h0000_2345, Z_GREATER, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL backpressure hold cycle %0d: v=%b id=%b res=%h z=%b r0=%b r1=%b required 1/0/00002345/%b/0/0",
                 i, rsp_valid, rsp_id, rsp_result, rsp_zero, req0_ready, req1_ready, Z_GREATER);
      end
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin
      failures++;
      $display("FAIL backpressure consume cycle: v=%b r0=%b r1=%b required 1/0/0",
               rsp_valid, req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || (req0_ready ^ req1_ready) !== 1'b1) begin
      failures++;
      $display("FAIL backpressure accept resumes: v=%b r0=%b r1=%b required v=0 and one ready",
               rsp_valid, req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    apply_reset();
  endtask

  task automatic test_contention();
    int  n;
    bit  ids [4];
    bit  exp_id;
    apply_reset();
    n = 0;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_mode = M_ADD;
    req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_mode = M_SUB;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids[n] = rsp_id;
        checks++;
        if (rsp_result !== (rsp_id ? 32'd18 : 32'd11)) begin
          failures++;
          $display("FAIL contention result op %0d: got %h for id %0d required %h",
                   n, rsp_result, rsp_id, rsp_id ? 32'd18 : 32'd11);
        end
        n++;
      end
      @(posedge clk);
      #1;
      if (n == 4) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL contention response count: got %0d required 4", n);
    end
    for (int k = 0; k < n; k++) begin
`ifdef ALU_ARB_RR_EN
      exp_id = k[0];
`else
      exp_id = 1'b0;
`endif
      checks++;
      if (ids[k] !== exp_id) begin
        failures++;
        $display("FAIL contention rsp_id op %0d: got %0d required %0d", k, ids[k], exp_id);
      end
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_resp();
    bit hs_ok, rsp_ok, got_id, seen;
    int lat;
    logic [31:0] res;
    logic [1:0]  z;
    apply_reset();
    rsp_ready = 1'b0;
    run_op(1'b1, 32'hA5A5_0000, 32'd3, M_OR, hs_ok, rsp_ok, lat, got_id, res, z);
    checks++;
    if (rsp_valid !== 1'b1 || alu_a !== 32'hA5A5_0000) begin
      failures++;
      $display("FAIL reset_mid_resp precondition: v=%b alu_a=%h required 1/a5a50000",
               rsp_valid, alu_a);
    end
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_mode = M_ADD;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000 || alu_a !== 32'd0 ||
        rsp_result !== 32'd0 || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_resp immediate: v=%b r0=%b r1=%b alu_a=%h res=%h id=%b required all 0",
               rsp_valid, req0_ready, req1_ready, alu_a, rsp_result, rsp_id);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    rst        = 1'b0;
    seen       = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_resp stale response: rsp_valid seen=%b required 0", seen);
    end
  endtask

  // Randomized traffic against a transaction-level model: at most one
  // outstanding op, response visible from two cycles after its handshake
  // until consumed, grants only while nothing is outstanding.
  task automatic test_random();
    bit          outst, oid, prefer, exp_r0, exp_r1, exp_v;
    int          age;
    logic [31:0] oa, ob;
    logic [3:0]  om;
    logic [33:0] exp_rz;
    apply_reset();
    outst  = 1'b0;
    prefer = 1'b0;
    oid    = 1'b0;
    age    = 0;
    oa     = '0;
    ob     = '0;
    om     = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_a     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom;
      req0_b     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom;
      req1_a     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom;
      req1_b     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom;
      req0_mode  = 4'($urandom_range(0, 15));
      req1_mode  = 4'($urandom_range(0, 15));
      rsp_ready  = ($urandom_range(0, 9) < 7);
      @(negedge clk);

`ifdef ALU_ARB_RR_EN
      exp_r0 = !outst && req0_valid && (!req1_valid || prefer == 1'b0);
      exp_r1 = !outst && req1_valid && (!req0_valid || prefer == 1'b1);
`else
      exp_r0 = !outst && req0_valid;
      exp_r1 = !outst && req1_valid && !req0_valid;
`endif
      checks++;
      if ({req1_ready, req0_ready} !== {exp_r1, exp_r0}) begin
        failures++;
        $display("FAIL random ready cycle %0d: got r1r0=%b%b required %b%b",
                 cyc, req1_ready, req0_ready, exp_r1, exp_r0);
      end

      exp_v = outst && (age >= 2);
      checks++;
      if (rsp_valid !== exp_v) begin
        failures++;
        $display("FAIL random rsp_valid cycle %0d: got %b required %b", cyc, rsp_valid, exp_v);
      end
      if (exp_v && rsp_valid) begin
        exp_rz = alu_fn(oa, ob, om);
        checks++;
        if ({rsp_id, rsp_zero, rsp_result} !== {oid, exp_rz}) begin
          failures++;
          $display("FAIL random response cycle %0d: got id=%b z=%b res=%h required id=%b z=%b res=%h",
                   cyc, rsp_id, rsp_zero, rsp_result, oid, exp_rz[33:32], exp_rz[31:0]);
        end
      end

      // Advance the model across the coming clock edge.
      if (outst) begin
        if (exp_v && rsp_ready) outst = 1'b0;
        else                    age++;
      end else if (exp_r0 || exp_r1) begin
        outst  = 1'b1;
        age    = 1;
        oid    = exp_r1;
        oa     = exp_r1 ? req1_a    : req0_a;
        ob     = exp_r1 ? req1_b    : req0_b;
        om     = exp_r1 ? req1_mode : req0_mode;
        prefer = !exp_r1;
      end
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_compare();
    test_sub_shift();
    test_back_pressure();
    test_contention();
    test_reset_mid_resp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
